pwm_bank: RTL and testbench

- Parametrised multi-channel PWM generator; the generalised successor of the single-channel SPI-driven PWM peripheral in the top-level project.
- One shared prescaler and period counter drive CHANNELS independent duty comparators.
- Each channel has a double-buffered duty register, so updates take effect glitch-free at the period boundary.
- Sits behind the SPI register file; its outputs feed uo_out/uio_out through the top-level wrapper.

---
 rtl/pwm_bank.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator.
// One shared prescaler and period counter drive CHANNELS duty comparators.
// Every channel has a shadow duty register and an active duty register. The
// active registers reload from the shadows only at a period boundary, so
// updates never cut a pulse short. The period register is handled the same way.
// Optional build macro: PWM_BANK_CENTER_ALIGN_EN adds the `mode` input and
// center-aligned (up/down) counting. Without it the bank is edge-aligned only.
module pwm_bank #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 8,
   parameter int PRESC_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic [PRESC_W-1:0]  prescale,
`ifdef PWM_BANK_CENTER_ALIGN_EN
   input  logic                mode,
`endif
   input  logic                wr_en,
   input  logic [4:0]          wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_tick,
   output logic [WIDTH-1:0]    cnt
);

   localparam logic [4:0] PERIOD_ADDR = 5'd31;

   genvar gi;

   // Shared timebase state
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic               wrap_q, wrap_d;
   logic [WIDTH-1:0]   period_sh_q, period_sh_d;
   logic [WIDTH-1:0]   period_act_q, period_act_d;
   logic               tick;
   logic               load;

`ifdef PWM_BANK_CENTER_ALIGN_EN
   logic               mode_act_q, mode_act_d;
   logic               cnt_down_q, cnt_down_d;
`endif

   // The counter advances once every prescale+1 clocks. Using >= instead of ==
   // also recovers at once if prescale is lowered below the running count.
   always_comb begin
      tick = en && (presc_q >= prescale);
   end

   // Prescaler and period counter; wrap_d marks the tick that ends a period.
   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
      cnt_down_d = cnt_down_q;
`endif
      if (!en) begin
         // The bank is idle. Hold the timebase at the start of a period.
         presc_d = '0;
         cnt_d   = '0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
         cnt_down_d = 1'b0;
`endif
      end else if (!tick) begin
         presc_d = presc_q + 1'b1;
      end else begin
         presc_d = '0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
         if (mode_act_q) begin
            // Up/down counting. The period ends at the cnt=0 turning point.
            if (period_act_q == '0) begin
               cnt_d      = '0;
               wrap_d     = 1'b1;
               cnt_down_d = 1'b0;
            end else if (!cnt_down_q) begin
               if (cnt_q >= period_act_q) begin
                  if (cnt_q <= WIDTH'(1)) begin
                     // Period 1: the top turns straight back into zero.
                     cnt_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     cnt_d      = cnt_q - 1'b1;
                     cnt_down_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               if (cnt_q <= WIDTH'(1)) begin
                  cnt_d      = '0;
                  wrap_d     = 1'b1;
                  cnt_down_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end else
`endif
         begin
            // Edge-aligned counting: 0..period, then back to 0.
            if (cnt_q == period_act_q) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // Active registers reload at a wrap, and on every clock while disabled.
   assign load = wrap_d || !en;

   // Period shadow write and active period reload.
   always_comb begin
      period_sh_d  = period_sh_q;
      period_act_d = period_act_q;
      if (wr_en && (wr_addr == PERIOD_ADDR)) begin
         period_sh_d = wr_data;
      end
      // The reload takes the shadow value from before any write on the same edge.
      if (load) begin
         period_act_d = period_sh_q;
      end
   end

`ifdef PWM_BANK_CENTER_ALIGN_EN
   // The counting mode is sampled only at a period boundary, or while idle.
   always_comb begin
      mode_act_d = load ? mode : mode_act_q;
   end
`endif

   // Shared timebase registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         wrap_q       <= 1'b0;
         period_sh_q  <= '1;
         period_act_q <= '1;
      end else begin
         presc_q      <= presc_d;
         cnt_q        <= cnt_d;
         wrap_q       <= wrap_d;
         period_sh_q  <= period_sh_d;
         period_act_q <= period_act_d;
      end
   end

`ifdef PWM_BANK_CENTER_ALIGN_EN
   // Center-aligned mode and direction registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_act_q <= 1'b0;
         cnt_down_q <= 1'b0;
      end else begin
         mode_act_q <= mode_act_d;
         cnt_down_q <= cnt_down_d;
      end
   end
`endif

   assign period_tick = wrap_q;
   assign cnt         = cnt_q;

   // Per-channel shadow and active duty registers and the output comparator.
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
         logic [WIDTH-1:0] duty_act_q, duty_act_d;
         logic             pwm_q, pwm_d;
         logic             sel;

         assign sel = wr_en && (wr_addr == 5'(gi));

         // Shadow write, reload at a boundary, and compare against the counter.
         always_comb begin
            duty_sh_d  = sel ? wr_data : duty_sh_q;
            duty_act_d = load ? duty_sh_q : duty_act_q;
            pwm_d      = en && ch_en[gi] && (cnt_q < duty_act_q);
         end

         // Channel registers. The output is registered, one clock after cnt.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               duty_sh_q  <= '0;
               duty_act_q <= '0;
               pwm_q      <= 1'b0;
            end else begin
               duty_sh_q  <= duty_sh_d;
               duty_act_q <= duty_act_d;
               pwm_q      <= pwm_d;
            end
         end

         assign pwm_out[gi] = pwm_q;
      end
   endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed and randomized checks of pwm_bank (default 8x8 build).
// A period-level model (clocks elapsed inside the current period, divided by
// prescale+1) predicts cnt, period_tick and pwm_out on every clock. Directed
// windows pin the model with hand-computed pulse widths and period lengths.
`timescale 1ns/1ps
module tb_pwm_bank;
   localparam int CH   = 8;
   localparam int W    = 8;
   localparam int PW   = 8;
   localparam int MAXW = 600;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [CH-1:0] ch_en;
   logic [PW-1:0] prescale;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic [CH-1:0] pwm_out;
   logic          period_tick;
   logic [W-1:0]  cnt;
`ifdef PWM_BANK_CENTER_ALIGN_EN
   logic          mode = 1'b0;
`endif

   always #5 clk = ~clk;

   pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .ch_en(ch_en),
      .prescale(prescale),
`ifdef PWM_BANK_CENTER_ALIGN_EN
      .mode(mode),
`endif
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .pwm_out(pwm_out),
      .period_tick(period_tick),
      .cnt(cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_on   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int         sh_duty[CH];
   int         act_duty[CH];
   int         sh_per;
   int         act_per;
   int         elapsed;
   int         exp_cnt;
   bit         exp_tick;
   bit [CH-1:0] exp_pwm;

   task automatic model_step();
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            sh_duty[i]  = 0;
            act_duty[i] = 0;
         end
         sh_per   = (1 << W) - 1;
         act_per  = (1 << W) - 1;
         elapsed  = 0;
         exp_cnt  = 0;
         exp_tick = 1'b0;
         exp_pwm  = '0;
      end else begin
         if (!en) begin
            elapsed  = 0;
            exp_cnt  = 0;
            exp_tick = 1'b0;
            exp_pwm  = '0;
            act_per  = sh_per;
            for (int i = 0; i < CH; i++) act_duty[i] = sh_duty[i];
         end else begin
            for (int i = 0; i < CH; i++)
               exp_pwm[i] = ch_en[i] && (exp_cnt < act_duty[i]);
            elapsed++;
            exp_tick = 1'b0;
            if (elapsed == (act_per + 1) * (int'(prescale) + 1)) begin
               elapsed  = 0;
               exp_tick = 1'b1;
               act_per  = sh_per;
               for (int i = 0; i < CH; i++) act_duty[i] = sh_duty[i];
            end
            exp_cnt = elapsed / (int'(prescale) + 1);
         end
         if (wr_en) begin
            if (int'(wr_addr) < CH) sh_duty[wr_addr] = int'(wr_data);
            else if (wr_addr == 5'd31) sh_per = int'(wr_data);
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (cmp_on) begin
         chk("cnt", int'(cnt), exp_cnt);
         chk("period_tick", int'(period_tick), int'(exp_tick));
         chk("pwm_out", int'(pwm_out), int'(exp_pwm));
      end
   end

   // ---------------- stimulus helpers ----------------
   int hi_cnt[CH];

   // Called just after a negedge: one write cycle, returns after the next negedge.
   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = a[4:0];
      wr_data = d[7:0];
      @(negedge clk);
      wr_en   = 1'b0;
      $display("write addr=%0d data=%0d", a, d);
   endtask

   // Counts clocks and per-channel high clocks up to and including the next
   // period_tick sample; optionally issues a write after sample wr_at.
   task automatic measure(input int wr_at, input int a, input int d, output int gap);
      bit seen;
      seen = 1'b0;
      gap  = 0;
      for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
      for (int k = 1; k <= MAXW; k++) begin
         @(negedge clk);
         gap = k;
         for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
         if (k == wr_at) begin
            wr_en   = 1'b1;
            wr_addr = a[4:0];
            wr_data = d[7:0];
         end else begin
            wr_en = 1'b0;
         end
         if (period_tick) begin
            seen = 1'b1;
            break;
         end
      end
      wr_en = 1'b0;
      if (!seen) begin
         n_checks++;
         $display("FAIL measure_timeout: no period_tick within %0d clocks", MAXW);
      end
      $display("period gap=%0d hi=%0d,%0d,%0d,%0d,%0d", gap, hi_cnt[0], hi_cnt[1],
               hi_cnt[2], hi_cnt[3], hi_cnt[4]);
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < MAXW; k++) begin
         @(negedge clk);
         if (period_tick) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL wait_tick_timeout: no period_tick within %0d clocks", MAXW);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int gap;
      int r;
      int idx;
      rst      = 1'b1;
      en       = 1'b0;
      ch_en    = '1;
      prescale = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      repeat (3) @(negedge clk);
      cmp_on = 1'b1;
      rst    = 1'b0;
      @(negedge clk);
      chk("reset_cnt", int'(cnt), 0);
      chk("reset_tick", int'(period_tick), 0);
      chk("reset_pwm", int'(pwm_out), 0);

      // Basic duty with the period and duties loaded while disabled.
      wr(31, 9); wr(0, 3); wr(1, 0); wr(2, 12); wr(3, 9);
      @(negedge clk);
      en = 1'b1;
      measure(0, 0, 0, gap);
      chk("first_gap", gap, 10);
      chk("first_hi0", hi_cnt[0], 3);
      chk("first_hi1", hi_cnt[1], 0);
      chk("first_hi2", hi_cnt[2], 10);
      chk("first_hi3", hi_cnt[3], 9);
      measure(0, 0, 0, gap);
      chk("basic_gap", gap, 10);
      chk("basic_hi0", hi_cnt[0], 3);

      // Double buffering: a mid-period write lands at the next boundary,
      // and a write on the load edge lands one period later.
      measure(4, 0, 7, gap);
      chk("db_mid_hi0", hi_cnt[0], 3);
      measure(0, 0, 0, gap);
      chk("db_next_hi0", hi_cnt[0], 7);
      measure(9, 0, 2, gap);
      chk("db_load_hi0", hi_cnt[0], 7);
      measure(0, 0, 0, gap);
      chk("db_late_hi0", hi_cnt[0], 7);
      measure(0, 0, 0, gap);
      chk("db_applied_hi0", hi_cnt[0], 2);

      // Channel gating and writes to addresses that do not exist.
      ch_en[2] = 1'b0;
      @(negedge clk);
      chk("gate_off_ch2", int'(pwm_out[2]), 0);
      ch_en[2] = 1'b1;
      @(negedge clk);
      chk("gate_on_ch2", int'(pwm_out[2]), 1);
      wr(20, 5); wr(19, 1); wr(30, 2);
      wait_tick();
      measure(0, 0, 0, gap);
      chk("inval_gap", gap, 10);
      chk("inval_hi3", hi_cnt[3], 9);
      chk("inval_hi4", hi_cnt[4], 0);

      // Prescaler.
      en       = 1'b0;
      prescale = 8'd3;
      wr(31, 4); wr(0, 2);
      @(negedge clk);
      en = 1'b1;
      measure(0, 0, 0, gap);
      chk("presc_first_gap", gap, 20);
      chk("presc_first_hi0", hi_cnt[0], 8);
      measure(0, 0, 0, gap);
      chk("presc_gap", gap, 20);
      chk("presc_hi0", hi_cnt[0], 8);
      chk("presc_hi2", hi_cnt[2], 20);

      // Asynchronous reset in the middle of a period.
      en       = 1'b0;
      prescale = 8'd0;
      wr(31, 9); wr(0, 4);
      @(negedge clk);
      en = 1'b1;
      repeat (13) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_cnt", int'(cnt), 0);
      chk("async_rst_pwm", int'(pwm_out), 0);
      chk("async_rst_tick", int'(period_tick), 0);
      @(negedge clk);
      rst = 1'b0;
      measure(0, 0, 0, gap);
      chk("post_rst_gap", gap, 256);
      chk("post_rst_hi0", hi_cnt[0], 0);

      // Randomized traffic, checked only by the per-cycle model comparison.
      en = 1'b0;
      wr(31, 6);
      @(negedge clk);
      en = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         wr_en = 1'b0;
         if (r < 30) begin
            wr_en   = 1'b1;
            idx     = $urandom_range(0, 9);
            if (idx < 8) wr_addr = 5'(idx);
            else if (idx == 8) wr_addr = 5'd31;
            else wr_addr = 5'($urandom_range(8, 30));
            wr_data = (wr_addr == 5'd31) ? 8'($urandom_range(0, 12))
                                         : 8'($urandom_range(0, 14));
         end else if (r < 34) begin
            idx        = $urandom_range(0, CH - 1);
            ch_en[idx] = ~ch_en[idx];
         end else if (r < 35) begin
            if (en) prescale = 8'($urandom_range(0, 3));
            en = ~en;
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      @(negedge clk);

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
